// File: rtl/sifo_pkg.sv
// -----------------------------------------------------------------------------
// sifo_pkg
// Shared constants and types for the stream-in / RAM-write path.
//   DATA_W         : RAM word width
//   ADDR_W         : RAM address width
//   loader_state_t : mem_loader FSM states
// -----------------------------------------------------------------------------
package sifo_pkg;

   localparam int DATA_W = 10;
   localparam int ADDR_W = 14;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WRITE,
      RELEASE,
      DONE
   } loader_state_t;

endpackage

// File: rtl/loader_fifo.sv
// -----------------------------------------------------------------------------
// loader_fifo
// Small first-word-fall-through FIFO buffering stream words ahead of the RAM
// write port. The head word is visible combinationally so that a write can
// be issued in the same cycle the arbiter grants the port.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset (clears pointers)
//   push      in   write push_data this cycle
//   push_data in   word to store
//   pop       in   discard head word this cycle
//   head      out  oldest stored word
//   full      out  FIFO_DEPTH words stored
//   empty     out  no words stored
//   count     out  current occupancy
//
// Push and pop in the same cycle are both honoured; when full, a push is
// accepted only if a pop frees the slot in the same cycle.
// -----------------------------------------------------------------------------
module loader_fifo #(
   parameter int DATA_W     = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [DATA_W-1:0]            push_data,
   input  logic                         pop,
   output logic [DATA_W-1:0]            head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(FIFO_DEPTH):0]  count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   // Storage is not reset: the pointers alone define which entries are valid.
   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [PTR_W:0] wr_ptr_reg;
   logic [PTR_W:0] rd_ptr_reg;
   logic           do_push;
   logic           do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                    (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_reg[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
// Stream-to-RAM loader. Words arriving on a valid/ready stream are buffered
// in a FIFO and written to consecutive RAM addresses starting at base_addr.
// The RAM port is shared with the DMA through a request/grant arbiter; the
// loader gives the port back for one cycle after every BURST writes.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle pulse, latches base_addr/length (IDLE only)
//   base_addr  in   first RAM address
//   length     in   word count (0 completes immediately)
//   in_valid   in   stream word valid
//   in_data    in   stream word
//   in_ready   out  loader accepts a word this cycle
//   req        out  RAM port request to arbiter
//   grant      in   arbiter grant
//   ram_write  out  RAM write strobe
//   ram_addr   out  RAM write address (0 when not writing)
//   ram_indata out  RAM write data (0 when not writing)
//   busy       out  transfer in progress
//   done       out  one-cycle completion pulse
//   checksum   out  wrapping sum of written words (MEM_LOADER_CHECKSUM_EN)
//
// Build option: define MEM_LOADER_CHECKSUM_EN to add the checksum output.
// -----------------------------------------------------------------------------
module mem_loader #(
   parameter int DATA_W     = sifo_pkg::DATA_W,
   parameter int ADDR_W     = sifo_pkg::ADDR_W,
   parameter int FIFO_DEPTH = 8,
   parameter int BURST      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              req,
   input  logic              grant,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_indata,
   output logic              busy,
   output logic              done
`ifdef MEM_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   import sifo_pkg::*;

   localparam int BURST_W = $clog2(BURST + 1);
   localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;

   loader_state_t       state_reg;
   loader_state_t       state_next;

   logic [ADDR_W-1:0]   base_reg;
   logic [ADDR_W-1:0]   len_reg;
   logic [ADDR_W-1:0]   acc_cnt_reg;
   logic [ADDR_W-1:0]   wr_cnt_reg;
   logic [BURST_W-1:0]  burst_cnt_reg;

   logic                fifo_full;
   logic                fifo_empty;
   logic [FCNT_W-1:0]   fifo_count;
   logic [DATA_W-1:0]   fifo_head;

   logic                active;
   logic                accept;
   logic                write_en;
   logic                start_load;
   logic                last_write;
   logic                burst_end;
   logic                drain_end;

   // -------------------------------------------------------------------------
   // Stream side
   // -------------------------------------------------------------------------
   assign active     = (state_reg != IDLE) && (state_reg != DONE);
   assign busy       = active;
   assign in_ready   = active && !fifo_full && (acc_cnt_reg < len_reg);
   assign accept     = in_valid && in_ready;
   assign start_load = (state_reg == IDLE) && start;

   // A write only ever happens with grant present in the same cycle.
   assign write_en   = (state_reg == WRITE) && grant && !fifo_empty;

   // Exit conditions evaluated against the write happening this cycle.
   assign last_write = ((wr_cnt_reg + ADDR_W'(1)) == len_reg);
   assign burst_end  = ((burst_cnt_reg + BURST_W'(1)) == BURST_W'(BURST));
   // The FIFO runs dry after this pop unless a new word arrives alongside.
   assign drain_end  = (fifo_count == FCNT_W'(1)) && !accept;

   loader_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (in_data),
      .pop       (write_en),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      req        = 1'b0;
      ram_write  = 1'b0;
      ram_addr   = '0;
      ram_indata = '0;
      done       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (length == '0) ? DONE : REQ;
            end
         end

         REQ: begin
            // Do not sit on the port while there is nothing to write.
            req = !fifo_empty;
            if (grant && !fifo_empty) begin
               state_next = WRITE;
            end
         end

         WRITE: begin
            req = 1'b1;
            if (write_en) begin
               ram_write  = 1'b1;
               ram_addr   = base_reg + wr_cnt_reg;
               ram_indata = fifo_head;
            end
            if (!grant) begin
               state_next = REQ;
            end else if (fifo_empty) begin
               state_next = RELEASE;
            end else if (last_write) begin
               state_next = DONE;
            end else if (burst_end || drain_end) begin
               state_next = RELEASE;
            end
         end

         RELEASE: begin
            state_next = REQ;
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Transfer parameters and counters
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_reg      <= '0;
         len_reg       <= '0;
         acc_cnt_reg   <= '0;
         wr_cnt_reg    <= '0;
         burst_cnt_reg <= '0;
      end else if (start_load) begin
         base_reg      <= base_addr;
         len_reg       <= length;
         acc_cnt_reg   <= '0;
         wr_cnt_reg    <= '0;
         burst_cnt_reg <= '0;
      end else begin
         if (accept) begin
            acc_cnt_reg <= acc_cnt_reg + 1'b1;
         end
         if (write_en) begin
            wr_cnt_reg    <= wr_cnt_reg + 1'b1;
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
         end
         if (state_reg == RELEASE) begin
            burst_cnt_reg <= '0;
         end
      end
   end

`ifdef MEM_LOADER_CHECKSUM_EN
   // Wrapping sum of every word written; holds after done until next start.
   logic [DATA_W-1:0] checksum_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum_reg <= '0;
      end else if (start_load) begin
         checksum_reg <= '0;
      end else if (write_en) begin
         checksum_reg <= checksum_reg + fifo_head;
      end
   end

   assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
// Self-checking bench for mem_loader. Accepted stream words push the
// expected (address, data) pair to a scoreboard queue; a negedge monitor pops
// and compares on every ram_write. A table of load jobs is run in a loop,
// followed by hand-written sequences for the multi-cycle corner cases.
// Define MEM_LOADER_CHECKSUM_EN to also check the checksum output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_loader;

   localparam int DW = 10;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] length = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          req;
   logic          grant = 1'b0;
   logic          ram_write;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_indata;
   logic          busy;
   logic          done;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   mem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .req        (req),
      .grant      (grant),
      .ram_write  (ram_write),
      .ram_addr   (ram_addr),
      .ram_indata (ram_indata),
      .busy       (busy),
`ifdef MEM_LOADER_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      bit            grand;
      logic [AW-1:0] exp_last;
   } job_t;

   wr_t           exp_q[$];
   logic [DW-1:0] src_q[$];
   wr_t           mon_e;
   job_t          jobs[5];

   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   int            wr_seen = 0;
   int            req_hi_cnt = 0;
   int            req_drop_cnt = 0;
   int            last_wr_cyc = 0;
   int            last_done_cyc = 0;
   logic [AW-1:0] last_addr = '0;
   logic          req_prev = 1'b0;
   logic [AW-1:0] job_base = '0;
   int            job_idx = 0;
   logic [DW-1:0] exp_sum = '0;
   bit            abort = 1'b0;
   bit            job_end = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (ram_write === 1'b1) begin
         wr_seen++;
         last_wr_cyc = cyc;
         last_addr   = ram_addr;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                     ram_addr, ram_indata);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_addr", 32'(ram_addr), 32'(mon_e.addr));
            check("sb_data", 32'(ram_indata), 32'(mon_e.data));
            $display("[TB] write addr=0x%04h data=0x%03h", ram_addr, ram_indata);
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         last_done_cyc = cyc;
`ifdef MEM_LOADER_CHECKSUM_EN
         check("checksum_at_done", 32'(checksum), 32'(exp_sum));
`endif
      end
      if (req === 1'b1) req_hi_cnt++;
      if (busy === 1'b1 && req === 1'b0 && req_prev === 1'b1) req_drop_cnt++;
      req_prev = req;
   end

   // Called at posedge+1; start is sampled on the following edge.
   task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
      base_addr = b;
      length    = l;
      start     = 1'b1;
      job_base  = b;
      job_idx   = 0;
      exp_sum   = '0;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Offers every word of src_q; a word counts as accepted if in_ready is
   // high mid-cycle while it is offered.
   task automatic stream_all();
      int            budget;
      logic [DW-1:0] d;
      wr_t           e;
      budget = 0;
      while (src_q.size() != 0 && !abort) begin
         d        = src_q[0];
         in_valid = 1'b1;
         in_data  = d;
         @(negedge clk);
         if (in_ready === 1'b1) begin
            e.addr = AW'(32'(job_base) + job_idx);
            e.data = d;
            exp_q.push_back(e);
            exp_sum = exp_sum + d;
            job_idx++;
            void'(src_q.pop_front());
            budget = 0;
         end else begin
            budget++;
            if (budget > 200) begin
               tests++;
               fails++;
               $display("FAIL stream_timeout: got in_ready=0 for 200 cycles, expected acceptance");
               src_q.delete();
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("done_seen", 32'(done_cnt != d0), 32'd1);
   endtask

   task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] l, input bit grand,
                          input logic [AW-1:0] exp_last);
      int d0;
      int w0;
      d0      = done_cnt;
      w0      = wr_seen;
      grant   = 1'b1;
      job_end = 1'b0;
      do_start(b, l);
      fork
         stream_all();
         begin
            wait_done(d0);
            job_end = 1'b1;
         end
         begin
            while (grand && !job_end) begin
               grant = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            grant = 1'b1;
         end
      join
      check("job_write_count", 32'(wr_seen - w0), 32'(l));
      check("job_last_addr", 32'(last_addr), 32'(exp_last));
      check("job_done_latency", 32'(last_done_cyc - last_wr_cyc), 32'd1);
      check("job_sb_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("job_single_done", 32'(done_cnt - d0), 32'd1);
      check("job_idle", 32'(busy), 32'd0);
      $display("[TB] job base=0x%04h len=%0d grant_rand=%0d finished", b, l, grand);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int w0;
      int r0;
      int drops0;
      int n;

      jobs[0] = '{base: 14'h3FFE, len: 14'd4,  grand: 1'b0, exp_last: 14'h0001};
      jobs[1] = '{base: 14'h0100, len: 14'd1,  grand: 1'b0, exp_last: 14'h0100};
      jobs[2] = '{base: 14'h1234, len: 14'd9,  grand: 1'b1, exp_last: 14'h123C};
      jobs[3] = '{base: 14'h3FFA, len: 14'd20, grand: 1'b1, exp_last: 14'h000D};
      jobs[4] = '{base: 14'h0000, len: 14'd5,  grand: 1'b0, exp_last: 14'h0004};

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",   32'(in_ready),   32'd0);
      check("rst_req",        32'(req),        32'd0);
      check("rst_ram_write",  32'(ram_write),  32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_ram_addr",   32'(ram_addr),   32'd0);
      check("rst_ram_indata", 32'(ram_indata), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // ---- basic load ----
      src_q = '{10'h001, 10'h002, 10'h3FF};
      run_job(14'h0010, 14'd3, 1'b0, 14'h0012);

      // ---- zero length ----
      d0 = done_cnt;
      r0 = req_hi_cnt;
      w0 = wr_seen;
      do_start(14'h0123, 14'd0);
      @(negedge clk);
      #1;
      check("zl_done_pulse", 32'(done), 32'd1);
      check("zl_busy",       32'(busy), 32'd0);
      @(negedge clk);
      #1;
      check("zl_done_low",   32'(done), 32'd0);
      check("zl_done_count", 32'(done_cnt - d0), 32'd1);
      check("zl_no_req",     32'(req_hi_cnt - r0), 32'd0);
      check("zl_no_write",   32'(wr_seen - w0), 32'd0);
      @(posedge clk);
      #1;

      // ---- table of load jobs ----
      for (int j = 0; j < 5; j++) begin
         for (int k = 0; k < int'(jobs[j].len); k++) src_q.push_back(10'($urandom));
         run_job(jobs[j].base, jobs[j].len, jobs[j].grand, jobs[j].exp_last);
      end

      // ---- grant withdrawal, backpressure, burst release ----
      for (int k = 0; k < 10; k++) src_q.push_back(10'($urandom));
      d0     = done_cnt;
      w0     = wr_seen;
      drops0 = req_drop_cnt;
      grant  = 1'b0;
      do_start(14'h0200, 14'd10);
      fork
         stream_all();
         begin
            repeat (15) @(posedge clk);
            #1;
            check("bp_accepted",    32'(exp_q.size()), 32'd8);
            check("bp_in_ready",    32'(in_ready), 32'd0);
            check("bp_no_write",    32'(wr_seen - w0), 32'd0);
            check("bp_req_held",    32'(req), 32'd1);
            grant = 1'b1;
            n = 0;
            while (in_ready !== 1'b1 && n < 20) begin
               @(posedge clk);
               #1;
               n++;
            end
            check("bp_ready_back", 32'(in_ready), 32'd1);
            wait_done(d0);
         end
      join
      check("burst_req_drops", 32'(req_drop_cnt - drops0), 32'd2);
      check("burst_writes",    32'(wr_seen - w0), 32'd10);
      check("burst_last_addr", 32'(last_addr), 32'h209);
      check("burst_sb_empty",  32'(exp_q.size()), 32'd0);
      $display("[TB] burst/backpressure sequence finished");
      repeat (2) @(posedge clk);
      #1;

      // ---- mid-transfer reset ----
      for (int k = 0; k < 6; k++) src_q.push_back(10'($urandom));
      d0    = done_cnt;
      w0    = wr_seen;
      grant = 1'b1;
      abort = 1'b0;
      do_start(14'h0040, 14'd6);
      fork
         stream_all();
         begin
            n = 0;
            while ((wr_seen - w0) < 2 && n < 50) begin
               @(posedge clk);
               n++;
            end
            check("mr_two_writes", 32'(wr_seen - w0), 32'd2);
            #3;
            rst   = 1'b0;
            abort = 1'b1;
            #1;
            check("mr_in_ready",   32'(in_ready),   32'd0);
            check("mr_req",        32'(req),        32'd0);
            check("mr_ram_write",  32'(ram_write),  32'd0);
            check("mr_busy",       32'(busy),       32'd0);
            check("mr_done",       32'(done),       32'd0);
            check("mr_ram_addr",   32'(ram_addr),   32'd0);
            check("mr_ram_indata", 32'(ram_indata), 32'd0);
         end
      join
      in_valid = 1'b0;
      exp_q.delete();
      src_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b1;
      abort = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mr_no_done", 32'(done_cnt - d0), 32'd0);
      check("mr_idle",    32'(busy), 32'd0);
      $display("[TB] mid-transfer reset sequence finished");

      // ---- reload after reset ----
      src_q = '{10'h200, 10'h300};
      run_job(14'h0080, 14'd2, 1'b0, 14'h0081);
`ifdef MEM_LOADER_CHECKSUM_EN
      check("checksum_hold", 32'(checksum), 32'h100);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
